// File: rtl/dvp_camera_emulator.sv
// DVP (OV7670-style) camera transmitter: serialises a 16-bit pixel stream into
// pclk/vsync/href/data with programmable line and frame timing.
module dvp_camera_emulator #(
    parameter int CLK_DIV       = 8,
    parameter int H_ACTIVE      = 320,
    parameter int V_ACTIVE      = 240,
    parameter int H_BLANK       = 144,
    parameter int VSYNC_LINES   = 3,
    parameter int V_FRONT_LINES = 17,
    parameter int V_BACK_LINES  = 10
) (
    input  logic        clk_pixel_in,
    input  logic        rst_n_in,
    input  logic        enable_in,
    input  logic [15:0] pixel_in,
    input  logic        pixel_valid_in,
    input  logic        pixel_sof_in,
    output logic        pixel_ready_out,
    output logic        cam_pclk_out,
    output logic        cam_vsync_out,
    output logic        cam_href_out,
    output logic [7:0]  cam_data_out,
    output logic        frame_start_out,
    output logic        underflow_out,
    output logic        sof_error_out
);

    localparam int LINE_PCLKS = 2 * H_ACTIVE + H_BLANK;
    localparam int HREF_PCLKS = 2 * H_ACTIVE;
    localparam int MAX_A      = (VSYNC_LINES > V_FRONT_LINES) ? VSYNC_LINES : V_FRONT_LINES;
    localparam int MAX_B      = (V_ACTIVE > V_BACK_LINES) ? V_ACTIVE : V_BACK_LINES;
    localparam int MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int H_W        = $clog2(LINE_PCLKS + 1);
    localparam int V_W        = $clog2(MAX_LINES + 1);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VFRONT,
        ACTIVE,
        VBACK
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [DIV_W-1:0] div_cnt_reg;
    logic             pclk_reg;
    logic             fall_tick;
    logic [H_W-1:0]   hcnt_reg;
    logic [H_W-1:0]   hcnt_next;
    logic [V_W-1:0]   vcnt_reg;
    logic [V_W-1:0]   vcnt_next;
    logic [V_W-1:0]   phase_last;
    logic             line_end;
    logic             phase_end;
    logic             href_next;
    logic             fetch;
    logic             sof_slot;
    logic             vsync_reg;
    logic             href_reg;
    logic [7:0]       data_reg;
    logic [7:0]       lo_byte_reg;
    logic             frame_start_reg;
    logic             underflow_reg;
    logic             sof_error_reg;

    // Free-running divider; pclk falls on the same edge that updates the pins.
    assign fall_tick = (div_cnt_reg == '0);

    always_ff @(posedge clk_pixel_in) begin
        if (!rst_n_in) begin
            div_cnt_reg <= '0;
            pclk_reg    <= 1'b0;
        end else begin
            div_cnt_reg <= (div_cnt_reg == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt_reg + 1'b1;
            pclk_reg    <= (div_cnt_reg >= DIV_W'(CLK_DIV / 2));
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        if (!rst_n_in) begin
            state_reg <= IDLE;
            hcnt_reg  <= '0;
            vcnt_reg  <= '0;
        end else if (fall_tick) begin
            state_reg <= state_next;
            hcnt_reg  <= hcnt_next;
            vcnt_reg  <= vcnt_next;
        end
    end

    always_comb begin
        phase_last = '0;
        case (state_reg)
            VSYNC:   phase_last = V_W'(VSYNC_LINES - 1);
            VFRONT:  phase_last = V_W'(V_FRONT_LINES - 1);
            ACTIVE:  phase_last = V_W'(V_ACTIVE - 1);
            VBACK:   phase_last = V_W'(V_BACK_LINES - 1);
            default: phase_last = '0;
        endcase
    end

    assign line_end  = (hcnt_reg == H_W'(LINE_PCLKS - 1));
    assign phase_end = line_end && (vcnt_reg == phase_last);

    always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        vcnt_next  = vcnt_reg;
        if (state_reg == IDLE) begin
            hcnt_next = '0;
            vcnt_next = '0;
            if (enable_in) begin
                state_next = VSYNC;
            end
        end else begin
            hcnt_next = line_end ? '0 : hcnt_reg + 1'b1;
            if (line_end) begin
                vcnt_next = phase_end ? '0 : vcnt_reg + 1'b1;
            end
            if (phase_end) begin
                case (state_reg)
                    VSYNC:   state_next = VFRONT;
                    VFRONT:  state_next = ACTIVE;
                    ACTIVE:  state_next = VBACK;
                    VBACK:   state_next = enable_in ? VSYNC : IDLE;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Everything below describes the pclk period that begins at this fall tick.
    assign href_next = (state_next == ACTIVE) && (hcnt_next < H_W'(HREF_PCLKS));
    assign fetch     = href_next && !hcnt_next[0];
    assign sof_slot  = (vcnt_next == '0) && (hcnt_next == '0);

    assign pixel_ready_out = fall_tick && fetch;

    always_ff @(posedge clk_pixel_in) begin
        if (!rst_n_in) begin
            vsync_reg       <= 1'b1;
            href_reg        <= 1'b0;
            data_reg        <= 8'h00;
            lo_byte_reg     <= 8'h00;
            frame_start_reg <= 1'b0;
            underflow_reg   <= 1'b0;
            sof_error_reg   <= 1'b0;
        end else begin
            frame_start_reg <= 1'b0;
            if (fall_tick) begin
                vsync_reg       <= (state_next == IDLE) || (state_next == VSYNC);
                href_reg        <= href_next;
                frame_start_reg <= (state_reg == VSYNC) && (state_next == VFRONT);
                if (fetch) begin
                    if (pixel_valid_in) begin
                        data_reg    <= pixel_in[15:8];
                        lo_byte_reg <= pixel_in[7:0];
                        if (pixel_sof_in != sof_slot) begin
                            sof_error_reg <= 1'b1;
                        end
                    end else begin
                        // Missing pixel goes out as zeros so later pixels stay aligned.
                        data_reg      <= 8'h00;
                        lo_byte_reg   <= 8'h00;
                        underflow_reg <= 1'b1;
                    end
                end else if (href_next) begin
                    data_reg <= lo_byte_reg;
                end else begin
                    data_reg <= 8'h00;
                end
            end
        end
    end

    assign cam_pclk_out    = pclk_reg;
    assign cam_vsync_out   = vsync_reg;
    assign cam_href_out    = href_reg;
    assign cam_data_out    = data_reg;
    assign frame_start_out = frame_start_reg;
    assign underflow_out   = underflow_reg;
    assign sof_error_out   = sof_error_reg;

endmodule

// File: doc/dvp_camera_emulator.md
Name: dvp_camera_emulator

Overview:
- Synthesizable DVP (OV7670-style) camera transmitter that turns a 16-bit pixel stream into camera pins: pclk, vsync, href and 8-bit data.
- Replaces the physical camera in simulation and in on-board loopback tests, so the capture path and QR pipeline can run from known frames.
- Runs on the system pixel clock and generates pclk internally by division.

Parameters:
- CLK_DIV, 8: clk_pixel_in cycles per pclk period; even, >=4.
- H_ACTIVE, 320: pixels per line; each pixel is 2 bytes, so 2*H_ACTIVE pclks with href high.
- V_ACTIVE, 240: active lines per frame.
- H_BLANK, 144: pclks with href low after each active line.
- VSYNC_LINES, 3: line times with vsync high.
- V_FRONT_LINES, 17: line times after vsync falls, before the first active line.
- V_BACK_LINES, 10: line times after the last active line, before vsync rises.

Ports:
- clk_pixel_in  input  1  system pixel clock.
- rst_n_in  input  1  synchronous, active-low reset.
- enable_in  input  1  start and continue frames.
- pixel_in  input  16  pixel word; [15:8] is sent first.
- pixel_valid_in  input  1  pixel_in is valid.
- pixel_sof_in  input  1  marks the word as the first pixel of a frame.
- pixel_ready_out  output  1  one-cycle pulse; the word is consumed if valid.
- cam_pclk_out  output  1  generated pixel clock.
- cam_vsync_out  output  1  frame sync, high during vertical sync.
- cam_href_out  output  1  high during active bytes.
- cam_data_out  output  8  byte data.
- frame_start_out  output  1  one-cycle pulse when vsync falls.
- underflow_out  output  1  sticky: a pixel was needed but none was valid.
- sof_error_out  output  1  sticky: start-of-frame misalignment.

Behaviour:
- Reset values (rst_n_in low on a clock edge): all counters 0, state IDLE, pclk 0, vsync 1, href 0, data 0x00, ready 0, frame_start 0, underflow 0, sof_error 0.
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps. It always runs out of reset, whatever enable_in is.
  - cam_pclk_out = (div_cnt >= CLK_DIV/2), registered.
  - "Fall tick" is the cycle where div_cnt==0.
  - vsync, href, data and frame_start_out change only on fall ticks. This gives CLK_DIV/2 cycles of setup before the pclk rising edge where the receiver samples.
- Line time is L = 2*H_ACTIVE + H_BLANK pclks. A pclk counter (hcnt) and a line counter (vcnt) advance on fall ticks.
- State machine (transitions on fall ticks):
  - IDLE: vsync=1, href=0. Goes to VSYNC when enable_in=1.
  - VSYNC: vsync=1 for VSYNC_LINES*L pclks, then goes to VFRONT. On entry to VFRONT, vsync falls and frame_start_out pulses for one clk cycle.
  - VFRONT: vsync=0, href=0 for V_FRONT_LINES*L pclks, then goes to ACTIVE.
  - ACTIVE: per line, href=1 for hcnt < 2*H_ACTIVE, then 0 for H_BLANK pclks. After V_ACTIVE lines, goes to VBACK.
  - VBACK: V_BACK_LINES*L pclks with href=0, then:
    - to VSYNC if enable_in=1;
    - to IDLE otherwise (vsync rises either way).
- enable_in=0 mid-frame: the current frame completes unchanged. enable_in is sampled only at the end of VBACK.
- Byte sequencing in ACTIVE with href=1:
  - Even hcnt: drive pix[15:8], where pix is a pixel captured on the same fall tick.
  - Odd hcnt: drive the stored pix[7:0].
- Pixel fetch:
  - pixel_ready_out pulses on the even-hcnt fall tick only.
  - If pixel_valid_in=1: pixel_in is captured and consumed.
  - If pixel_valid_in=0: 0x0000 is sent, underflow_out is set, and nothing is consumed.
- SOF checking, applied to each consumed word:
  - Flag the error if pixel_sof_in=1 on any pixel other than (line 0, pixel 0).
  - Flag the error if pixel_sof_in=0 on (line 0, pixel 0).
  - On an error, set sof_error_out. Data is still sent; there is no resynchronization.
- href=0: cam_data_out=0x00.
- Reset mid-line: on the next cycle all outputs return to their reset values. A partially sent pixel is dropped, and no further ready pulse is issued until the next frame.
- Sticky flags clear only on reset.
- Throughput: one pixel per 2*CLK_DIV clk cycles during active lines.

Test Plan:
- Reset check: hold rst_n_in=0 for 20 cycles with enable_in=1 -> pclk=0, vsync=1, href=0, data=0, ready=0, flags=0; the pclk period is 8 clk cycles after release.
- Small frame: CLK_DIV=4, H_ACTIVE=2, V_ACTIVE=2, H_BLANK=3, VSYNC_LINES=1, V_FRONT_LINES=1, V_BACK_LINES=1. Feed 0x1234 (sof), 0xABCD, 0x00FF, 0x8001.
  - Bytes sampled on pclk rises = 12, 34, AB, CD (line 0) and 00, FF, 80, 01 (line 1).
  - href is high for 4 pclks per line, L=7.
  - vsync is high for 7 pclks; frame_start_out pulses once.
  - Exactly 4 ready pulses.
- Underflow: same config, pixel_valid_in=0 for the second pixel -> bytes 00,00 in that slot; underflow_out=1 and stays high; the following pixel is unshifted.
- SOF misalignment: first word without sof, then sof on the third word -> sof_error_out=1 after the first consumed word; the data stream is unchanged.
- Enable drop: deassert enable_in during line 0 of frame 1 -> the frame finishes with both lines intact, goes to IDLE with vsync=1, no further ready pulses; reassert -> a new VSYNC phase starts at the end of the next fall tick.
- Loopback: connect to the team's DVP capture block with default parameters, 320x240 counting pattern -> the captured 16-bit words equal the source words, in order, for 2 consecutive frames.
